// File: rtl/mc_resp_pkg.sv
// mc_resp_pkg: command codes, entry header layout and request validity helper for the MC port responder
package mc_resp_pkg;
  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_RD8 = 3'd1;
  localparam logic [2:0] CMD_WR8 = 3'd2;
  localparam logic [2:0] RS_RD_DATA = 3'd2;
  localparam logic [2:0] RS_WR_CMP = 3'd3;
  localparam logic [1:0] SIZE_8B = 2'd3;
  typedef struct packed {
    logic flush;
    logic [2:0] cmd;
    logic [3:0] scmd;
    logic [1:0] size;
    logic [63:0] data;
  } req_hdr_t;
  localparam int HDR_W = $bits(req_hdr_t);
  function automatic logic req_ok(logic [2:0] cmd, logic [1:0] size);
    return (cmd == CMD_RD8 || cmd == CMD_WR8) && size == SIZE_8B;
  endfunction
endpackage

// File: rtl/mc_port_responder_if.sv
// mc_port_responder_if: personality-facing mc_rq_*/mc_rs_* bundle, slave is the MC side
interface mc_port_responder_if #(
  parameter int RTNCTL_WIDTH = 32
);
  logic mc_rq_vld;
  logic [2:0] mc_rq_cmd;
  logic [3:0] mc_rq_scmd;
  logic [47:0] mc_rq_vadr;
  logic [1:0] mc_rq_size;
  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
  logic [63:0] mc_rq_data;
  logic mc_rq_flush;
  logic mc_rq_stall;
  logic mc_rs_vld;
  logic [2:0] mc_rs_cmd;
  logic [3:0] mc_rs_scmd;
  logic [63:0] mc_rs_data;
  logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
  logic mc_rs_stall;
  logic mc_rs_flush_cmplt;
  logic err;
  modport slave (
    input mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size, mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
    output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl, mc_rs_flush_cmplt, err
  );
  modport master (
    output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size, mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
    input mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl, mc_rs_flush_cmplt, err
  );
endinterface

// File: rtl/mc_resp_fifo.sv
// mc_resp_fifo: show-ahead FIFO with up to two ordered pushes per cycle and an occupancy count
module mc_resp_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input logic clk,
  input logic rst,
  input logic i_wr_a,
  input logic [W-1:0] i_din_a,
  input logic i_wr_b,
  input logic [W-1:0] i_din_b,
  input logic i_pop,
  output logic [W-1:0] o_dout,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp, w_wp_b;
  logic [AW:0] r_count;
  logic [1:0] w_nwr;
  assign w_wp_b = r_wp + AW'(i_wr_a);
  assign w_nwr = 2'(i_wr_a) + 2'(i_wr_b);
  assign o_dout = r_mem[r_rp];
  assign o_count = r_count;
  // storage: the second push lands behind the first when both fire
  always_ff @(posedge clk) begin
    if (i_wr_a) r_mem[r_wp] <= i_din_a;
    if (i_wr_b) r_mem[w_wp_b] <= i_din_b;
  end
  // pointers wrap naturally at DEPTH; the caller never overfills or pops empty
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_nwr);
      r_rp <= r_rp + AW'(i_pop);
      r_count <= r_count + (AW+1)'(w_nwr) - (AW+1)'(i_pop);
    end
  end
endmodule

// File: rtl/mc_port_responder.sv
// mc_port_responder: in-order MC port model servicing RD8/WR8 and flushes from a local 64-bit word memory
module mc_port_responder
  import mc_resp_pkg::*;
#(
  parameter int RTNCTL_WIDTH = 32,
  parameter int MEM_AW = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int STALL_SLACK = 4
) (
  input logic clk,
  input logic i_reset,
  mc_port_responder_if.slave mc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = HDR_W + MEM_AW + RTNCTL_WIDTH;
  req_hdr_t w_rq_hdr, w_hdr;
  logic [EW-1:0] w_ent_rq, w_ent_fl, w_din_a, w_dout;
  logic [MEM_AW-1:0] w_idx;
  logic [RTNCTL_WIDTH-1:0] w_tag;
  logic [CW-1:0] w_count, w_free, w_count_next;
  logic w_wr_a, w_wr_b, w_drop, w_pop, w_ok;
  logic [63:0] r_mem [2**MEM_AW];
  logic [63:0] r_rd_data;
  logic r_s1_rsp, r_s1_rd, r_s1_fl;
  logic [3:0] r_s1_scmd;
  logic [RTNCTL_WIDTH-1:0] r_s1_tag;
  logic r_rq_stall, r_rs_vld, r_fl_cmplt, r_err;
  logic [2:0] r_rs_cmd;
  logic [3:0] r_rs_scmd;
  logic [63:0] r_rs_data;
  logic [RTNCTL_WIDTH-1:0] r_rs_rtnctl;
  assign w_rq_hdr = '{flush: 1'b0, cmd: mc.mc_rq_cmd, scmd: mc.mc_rq_scmd, size: mc.mc_rq_size, data: mc.mc_rq_data};
  assign w_ent_rq = {w_rq_hdr, mc.mc_rq_vadr[MEM_AW+2:3], mc.mc_rq_rtnctl};
  assign w_ent_fl = {1'b1, (EW-1)'(0)};
  assign w_free = CW'(FIFO_DEPTH) - w_count;
  assign w_wr_a = (mc.mc_rq_vld | mc.mc_rq_flush) & (w_free != '0);
  assign w_wr_b = mc.mc_rq_vld & mc.mc_rq_flush & (w_free > CW'(1));
  assign w_din_a = mc.mc_rq_vld ? w_ent_rq : w_ent_fl;
  assign w_drop = ((mc.mc_rq_vld | mc.mc_rq_flush) & ~w_wr_a) | (mc.mc_rq_vld & mc.mc_rq_flush & ~w_wr_b);
  assign w_pop = ~i_reset & (w_count != '0) & ~mc.mc_rs_stall;
  assign {w_hdr, w_idx, w_tag} = w_dout;
  assign w_ok = ~w_hdr.flush & req_ok(w_hdr.cmd, w_hdr.size);
  assign w_count_next = w_count + CW'(w_wr_a) + CW'(w_wr_b) - CW'(w_pop);
  mc_resp_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(i_reset),
    .i_wr_a(w_wr_a),
    .i_din_a(w_din_a),
    .i_wr_b(w_wr_b),
    .i_din_b(w_ent_fl),
    .i_pop(w_pop),
    .o_dout(w_dout),
    .o_count(w_count)
  );
  // back-pressure tracks the occupancy that this edge produces
  always_ff @(posedge clk) begin
    r_rq_stall <= i_reset ? 1'b0 : w_count_next >= CW'(FIFO_DEPTH - STALL_SLACK);
  end
  // S1 memory: synchronous read, writes commit before any later entry reaches S1
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_rd_data <= r_mem[w_idx];
      if (w_ok && w_hdr.cmd == CMD_WR8) r_mem[w_idx] <= w_hdr.data;
    end
  end
  // S1 control: remember what the popped entry must produce at S2
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_s1_rsp <= 1'b0;
      r_s1_rd <= 1'b0;
      r_s1_fl <= 1'b0;
      r_s1_scmd <= '0;
      r_s1_tag <= '0;
    end else begin
      r_s1_rsp <= w_pop & w_ok;
      r_s1_rd <= w_hdr.cmd == CMD_RD8;
      r_s1_fl <= w_pop & w_hdr.flush;
      r_s1_scmd <= w_hdr.scmd;
      r_s1_tag <= w_tag;
    end
  end
  // S2 output registers: fields are zero whenever no response is presented
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_rs_vld <= 1'b0;
      r_rs_cmd <= '0;
      r_rs_scmd <= '0;
      r_rs_data <= '0;
      r_rs_rtnctl <= '0;
      r_fl_cmplt <= 1'b0;
    end else begin
      r_rs_vld <= r_s1_rsp;
      r_rs_cmd <= r_s1_rsp ? (r_s1_rd ? RS_RD_DATA : RS_WR_CMP) : CMD_IDLE;
      r_rs_scmd <= r_s1_rsp ? r_s1_scmd : '0;
      r_rs_data <= (r_s1_rsp & r_s1_rd) ? r_rd_data : '0;
      r_rs_rtnctl <= r_s1_rsp ? r_s1_tag : '0;
      r_fl_cmplt <= r_s1_fl;
    end
  end
  // sticky error: dropped pushes and unsupported cmd/size at consumption
  always_ff @(posedge clk) begin
    r_err <= i_reset ? 1'b0 : r_err | w_drop | (w_pop & ~w_hdr.flush & ~w_ok);
  end
  assign mc.mc_rq_stall = r_rq_stall;
  assign mc.mc_rs_vld = r_rs_vld;
  assign mc.mc_rs_cmd = r_rs_cmd;
  assign mc.mc_rs_scmd = r_rs_scmd;
  assign mc.mc_rs_data = r_rs_data;
  assign mc.mc_rs_rtnctl = r_rs_rtnctl;
  assign mc.mc_rs_flush_cmplt = r_fl_cmplt;
  assign mc.err = r_err;
endmodule

// File: tb/tb_mc_port_responder.sv
// tb_mc_port_responder: queue/array reference model with per-cycle compare plus directed literal checks
module tb_mc_port_responder;
  localparam int RW = 32, AW = 10, DEPTH = 16, SLACK = 4;
  logic clk = 1'b0;
  logic i_reset = 1'b1;
  always #5 clk = ~clk;
  mc_port_responder_if #(.RTNCTL_WIDTH(RW)) mc ();
  mc_port_responder #(.RTNCTL_WIDTH(RW), .MEM_AW(AW), .FIFO_DEPTH(DEPTH), .STALL_SLACK(SLACK)) dut (
    .clk(clk),
    .i_reset(i_reset),
    .mc(mc)
  );
  typedef struct {
    logic flush;
    logic [2:0] cmd;
    logic [3:0] scmd;
    logic [47:0] vadr;
    logic [1:0] size;
    logic [RW-1:0] tag;
    logic [63:0] data;
  } req_t;
  typedef struct {
    logic vld;
    logic fl;
    logic [2:0] cmd;
    logic [3:0] scmd;
    logic [RW-1:0] tag;
    logic [63:0] data;
    logic dc;
  } out_t;
  typedef struct {
    int cyc;
    logic [2:0] cmd;
    logic [RW-1:0] tag;
    logic [63:0] data;
  } rs_t;
  req_t q[$];
  req_t m_r;
  logic [63:0] mmem [int];
  out_t pend, expo;
  logic e_stall = 1'b0, e_err = 1'b0;
  int cyc = 0, n_cmp = 0, n_bad = 0, m_free, m_w, acc1, fl_cyc, run, viol;
  bit m_pop, chk_on = 1'b0;
  logic fl_vld;
  rs_t log[$];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // reference model: one queue of entries, results appear two edges after acceptance
  always @(posedge clk) begin
    cyc++;
    if (i_reset) begin
      q.delete();
      pend = '{default: 0};
      expo = '{default: 0};
      e_stall = 1'b0;
      e_err = 1'b0;
    end else begin
      m_free = DEPTH - q.size();
      m_pop = q.size() > 0 && !mc.mc_rs_stall;
      expo = pend;
      pend = '{default: 0};
      if (m_pop) begin
        m_r = q.pop_front();
        if (m_r.flush) pend.fl = 1'b1;
        else if ((m_r.cmd == 3'd1 || m_r.cmd == 3'd2) && m_r.size == 2'd3) begin
          m_w = int'(m_r.vadr[AW+2:3]);
          pend.vld = 1'b1;
          pend.scmd = m_r.scmd;
          pend.tag = m_r.tag;
          if (m_r.cmd == 3'd1) begin
            pend.cmd = 3'd2;
            if (mmem.exists(m_w)) pend.data = mmem[m_w];
            else pend.dc = 1'b1;
          end else begin
            pend.cmd = 3'd3;
            mmem[m_w] = m_r.data;
          end
        end else e_err = 1'b1;
      end
      if (mc.mc_rq_vld) begin
        if (m_free > 0) begin
          q.push_back('{1'b0, mc.mc_rq_cmd, mc.mc_rq_scmd, mc.mc_rq_vadr, mc.mc_rq_size, mc.mc_rq_rtnctl, mc.mc_rq_data});
          m_free--;
        end else e_err = 1'b1;
      end
      if (mc.mc_rq_flush) begin
        if (m_free > 0) q.push_back('{1'b1, 3'd0, 4'd0, 48'd0, 2'd0, '0, 64'd0});
        else e_err = 1'b1;
      end
      e_stall = q.size() >= DEPTH - SLACK;
    end
  end

  // compare every cycle and log observed responses
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rq_stall", 64'(mc.mc_rq_stall), 64'(e_stall));
      chk("rs_vld", 64'(mc.mc_rs_vld), 64'(expo.vld));
      chk("rs_cmd", 64'(mc.mc_rs_cmd), 64'(expo.cmd));
      chk("rs_scmd", 64'(mc.mc_rs_scmd), 64'(expo.scmd));
      chk("rs_rtnctl", 64'(mc.mc_rs_rtnctl), 64'(expo.tag));
      if (!expo.dc) chk("rs_data", mc.mc_rs_data, expo.data);
      chk("flush_cmplt", 64'(mc.mc_rs_flush_cmplt), 64'(expo.fl));
      chk("err", 64'(mc.err), 64'(e_err));
      if (mc.mc_rs_vld) log.push_back('{cyc, mc.mc_rs_cmd, mc.mc_rs_rtnctl, mc.mc_rs_data});
      if (mc.mc_rs_flush_cmplt) begin
        fl_cyc = cyc;
        fl_vld = mc.mc_rs_vld;
      end
    end
  end

  task automatic clr();
    mc.mc_rq_vld = 1'b0;
    mc.mc_rq_flush = 1'b0;
    mc.mc_rq_cmd = 3'd0;
    mc.mc_rq_scmd = 4'd0;
    mc.mc_rq_vadr = 48'd0;
    mc.mc_rq_size = 2'd0;
    mc.mc_rq_rtnctl = '0;
    mc.mc_rq_data = 64'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic [2:0] c, input logic [1:0] s,
                       input logic [47:0] a, input logic [RW-1:0] t, input logic [63:0] d);
    mc.mc_rq_vld = v;
    mc.mc_rq_flush = f;
    mc.mc_rq_cmd = c;
    mc.mc_rq_size = s;
    mc.mc_rq_vadr = a;
    mc.mc_rq_rtnctl = t;
    mc.mc_rq_data = d;
    mc.mc_rq_scmd = 4'(t);
    acc1 = cyc + 1;
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    int a0;
    clr();
    mc.mc_rs_stall = 1'b0;
    i_reset = 1'b1;
    idle(1);
    chk_on = 1'b1;
    idle(2);
    chk("reset_vld", 64'(mc.mc_rs_vld), 64'd0);
    chk("reset_stall", 64'(mc.mc_rq_stall), 64'd0);
    chk("reset_err", 64'(mc.err), 64'd0);
    i_reset = 1'b0;
    idle(2);
    // write then read the same word
    log.delete();
    drive(1, 0, 3'd2, 2'd3, 48'h40, 32'd5, 64'hDEADBEEF);
    a0 = acc1;
    drive(1, 0, 3'd1, 2'd3, 48'h40, 32'd6, 64'd0);
    idle(6);
    chk("t1_count", 64'(log.size()), 64'd2);
    if (log.size() == 2) begin
      chk("t1_lat", 64'(log[0].cyc - a0), 64'd2);
      chk("t1_wr_cmd", 64'(log[0].cmd), 64'd3);
      chk("t1_wr_tag", 64'(log[0].tag), 64'd5);
      chk("t1_rd_cmd", 64'(log[1].cmd), 64'd2);
      chk("t1_rd_tag", 64'(log[1].tag), 64'd6);
      chk("t1_rd_data", log[1].data, 64'hDEADBEEF);
    end
    // stall toggling every 3 cycles during 8 reads
    log.delete();
    run = 0;
    viol = 0;
    for (int t = 0; t < 30; t++) begin
      mc.mc_rs_stall = ((t / 3) % 2) == 1;
      if (t < 8) begin
        mc.mc_rq_vld = 1'b1;
        mc.mc_rq_cmd = 3'd1;
        mc.mc_rq_size = 2'd3;
        mc.mc_rq_vadr = 48'(t * 8);
        mc.mc_rq_rtnctl = 32'(300 + t);
      end else clr();
      run = mc.mc_rs_stall ? run + 1 : 0;
      @(posedge clk);
      #1;
      if (mc.mc_rs_vld && run >= 2) viol++;
    end
    clr();
    mc.mc_rs_stall = 1'b0;
    idle(8);
    chk("t3_burst", 64'(viol), 64'd0);
    chk("t3_count", 64'(log.size()), 64'd8);
    for (int i = 0; i < log.size(); i++) chk("t3_order", 64'(log[i].tag), 64'(300 + i));
    // three writes then a flush
    log.delete();
    fl_cyc = -1;
    for (int i = 0; i < 3; i++) drive(1, 0, 3'd2, 2'd3, 48'((32 + i) * 8), 32'(200 + i), {$urandom, $urandom});
    drive(0, 1, 3'd0, 2'd0, 48'd0, 32'd0, 64'd0);
    idle(8);
    chk("t4_count", 64'(log.size()), 64'd3);
    if (log.size() == 3) chk("t4_fl_time", 64'(fl_cyc), 64'(log[2].cyc + 1));
    chk("t4_fl_vld", 64'(fl_vld), 64'd0);
    // fill under response stall, overflow, then drain
    mc.mc_rs_stall = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      drive(1, 0, 3'd1, 2'd3, 48'(i * 8), 32'(100 + i), 64'd0);
      if (i == 11) chk("t2_stall11", 64'(mc.mc_rq_stall), 64'd0);
      if (i == 12) chk("t2_stall12", 64'(mc.mc_rq_stall), 64'd1);
    end
    chk("t2_err_pre", 64'(mc.err), 64'd0);
    drive(1, 0, 3'd1, 2'd3, 48'h8, 32'd999, 64'd0);
    chk("t2_err_ovf", 64'(mc.err), 64'd1);
    log.delete();
    mc.mc_rs_stall = 1'b0;
    idle(22);
    chk("t2_count", 64'(log.size()), 64'd16);
    for (int i = 0; i < log.size(); i++) begin
      chk("t2_order", 64'(log[i].tag), 64'(101 + i));
      chk("t2_spacing", 64'(log[i].cyc - log[0].cyc), 64'(i));
    end
    // reset with requests queued
    mc.mc_rs_stall = 1'b1;
    for (int i = 0; i < 5; i++) drive(1, 0, 3'd1, 2'd3, 48'h40, 32'(400 + i), 64'd0);
    log.delete();
    i_reset = 1'b1;
    mc.mc_rs_stall = 1'b0;
    idle(1);
    chk("t6_vld", 64'(mc.mc_rs_vld), 64'd0);
    chk("t6_stall", 64'(mc.mc_rq_stall), 64'd0);
    chk("t6_err", 64'(mc.err), 64'd0);
    chk("t6_data", mc.mc_rs_data, 64'd0);
    i_reset = 1'b0;
    idle(5);
    chk("t6_none", 64'(log.size()), 64'd0);
    drive(1, 0, 3'd1, 2'd3, 48'hFFFF_0000_0040, 32'd77, 64'd0);
    idle(4);
    chk("t6_count", 64'(log.size()), 64'd1);
    if (log.size() == 1) begin
      chk("t6_tag", 64'(log[0].tag), 64'd77);
      chk("t6_data_kept", log[0].data, 64'hDEADBEEF);
    end
    // unsupported size and command
    log.delete();
    chk("t5_err0", 64'(mc.err), 64'd0);
    drive(1, 0, 3'd1, 2'd2, 48'h40, 32'd50, 64'd0);
    drive(1, 0, 3'd5, 2'd3, 48'h40, 32'd51, 64'd0);
    idle(4);
    chk("t5_err1", 64'(mc.err), 64'd1);
    idle(5);
    chk("t5_err_sticky", 64'(mc.err), 64'd1);
    chk("t5_none", 64'(log.size()), 64'd0);
    // randomized traffic, one mid-run reset
    for (int t = 0; t < 400; t++) begin
      i_reset = (t == 200);
      mc.mc_rq_vld = 1'($urandom_range(0, 1));
      mc.mc_rq_cmd = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 2));
      mc.mc_rq_size = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'd3;
      mc.mc_rq_vadr = {16'($urandom), $urandom};
      mc.mc_rq_vadr[AW+2:3] = 10'($urandom_range(0, 15));
      mc.mc_rq_scmd = 4'($urandom);
      mc.mc_rq_rtnctl = $urandom;
      mc.mc_rq_data = {$urandom, $urandom};
      mc.mc_rq_flush = $urandom_range(0, 9) == 0;
      mc.mc_rs_stall = $urandom_range(0, 9) < 3;
      @(posedge clk);
      #1;
    end
    i_reset = 1'b0;
    clr();
    mc.mc_rs_stall = 1'b0;
    idle(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
